apb_cmd_master: RTL and testbench

Upstream neighbour of the APB4 memory slave wrapper. It converts a simple valid/ready command stream from test logic or an internal controller into single APB4 transfers on the s_* slave interface, and it returns one response per command through a valid/ready response port. It also rejects misaligned addresses without issuing an APB transfer, and aborts transfers that stall beyond a programmable wait limit.

---
 rtl/apb_cmd_master.sv | 131 +++++++++++++
 tb/tb_apb_cmd_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// Command-stream to APB4 master: one transfer per accepted command, one response per command.
// Misaligned addresses are answered without a bus cycle; stalled ACCESS phases abort after TIMEOUT_CYCLES.
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_CNT_W       = 16
) (
    input  logic                pclk,
    input  logic                preset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [2:0]          cmd_prot,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,

    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    output logic [2:0]          pprot,
    input  logic                pready,
    input  logic                pslverr,
    input  logic [DATA_W-1:0]   prdata
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t              r_state;
    logic [TO_CNT_W-1:0] r_to_cnt;
    logic [TO_CNT_W-1:0] w_to_next;
    logic                w_to_hit;

    assign w_to_next = r_to_cnt + 1'b1;
    assign w_to_hit  = (TIMEOUT_CYCLES != 0) && (w_to_next == TO_CNT_W'(TIMEOUT_CYCLES));

    // Gated by preset so the port reads 0 during reset yet accepts on the first edge after release.
    assign cmd_ready = (r_state == IDLE) && !preset;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state     <= IDLE;
            r_to_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_addr[1:0] != 2'b00) begin
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                            r_state     <= RESP;
                        end else begin
                            psel    <= 1'b1;
                            penable <= 1'b0;
                            paddr   <= cmd_addr;
                            pwrite  <= cmd_write;
                            pprot   <= cmd_prot;
                            pwdata  <= cmd_write ? cmd_wdata : '0;
                            pstrb   <= cmd_write ? cmd_strb  : '0;
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    r_to_cnt <= '0;
                    r_state  <= ACCESS;
                end
                ACCESS: begin
                    // Completion takes priority over a timeout landing on the same edge.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        r_state     <= RESP;
                    end else if (w_to_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        r_state     <= RESP;
                    end else begin
                        r_to_cnt <= w_to_next;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small APB4 memory slave (configurable waits, error, stall).
module tb_apb_cmd_master;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int checks   = 0;
    int failures = 0;

    apb_cmd_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(16),
        .TO_CNT_W(16)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // APB slave model
    logic [31:0] mem [0:63];
    int unsigned cfg_wait  = 0;
    bit          cfg_stuck = 0;
    bit          cfg_err   = 0;
    int unsigned wcnt      = 0;

    assign pready  = psel && penable && !cfg_stuck && (wcnt == cfg_wait);
    assign pslverr = pready && cfg_err;
    assign prdata  = mem[paddr[7:2]];

    always @(posedge pclk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
        if (psel && penable && pready && pwrite && !cfg_err)
            for (int b = 0; b < 4; b++)
                if (pstrb[b]) mem[paddr[7:2]][b*8 +: 8] <= pwdata[b*8 +: 8];
    end

    // Bus monitor, cleared at the start of each command
    int unsigned psel_cyc;
    int unsigned pen_cyc;
    bit          strb_bad;
    bit          pen_bad;
    bit          unstable;
    logic [31:0] setup_addr;

    always @(posedge pclk) begin
        if (psel) psel_cyc <= psel_cyc + 1;
        if (penable) pen_cyc <= pen_cyc + 1;
        if (psel && !pwrite && pstrb != 4'h0) strb_bad <= 1'b1;
        if (penable && !psel) pen_bad <= 1'b1;
        if (psel && !penable) setup_addr <= paddr;
        if (psel && penable && paddr != setup_addr) unstable <= 1'b1;
    end

    // Results of the last do_cmd
    bit          res_ok;
    int unsigned res_lat;
    logic [31:0] res_rdata;
    logic        res_err;
    logic        res_to;
    logic        res_rdy_in_resp;
    bit          res_hold;
    bit          res_drop;

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
        int n;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
        cmd_prot = 3'b010; cmd_valid = 1'b1;
        psel_cyc = 0; pen_cyc = 0; strb_bad = 0; pen_bad = 0; unstable = 0;
        res_ok = 0; n = 0;
        while (!res_ok && n < 20) begin
            res_ok = cmd_ready;
            @(posedge pclk); #1;
            n++;
        end
        cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFF1; cmd_wdata = 32'h5A5A_5A5A; cmd_write = ~wr;
    endtask

    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb);
        issue(wr, addr, wdata, strb);
        res_lat = 0;
        while (!rsp_valid && res_lat < 100) begin
            @(posedge pclk); #1;
            res_lat++;
        end
        res_rdata = rsp_rdata; res_err = rsp_err; res_to = rsp_timeout;
        res_rdy_in_resp = cmd_ready;
        @(posedge pclk); #1;
        res_hold = rsp_valid && rsp_rdata === res_rdata && rsp_err === res_err && rsp_timeout === res_to;
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        res_drop = !rsp_valid;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++; $display("FAIL reset_outputs got psel=%b pen=%b rv=%b crdy=%b exp all 0", psel, penable, rsp_valid, cmd_ready); end
        #11; preset = 1'b0; #1;
        checks++; if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); end
        @(posedge pclk); #1;
    endtask

    task automatic test_write_read;
        do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        checks++; if (!res_ok || res_lat != 2) begin
            failures++; $display("FAIL wr_latency got ok=%0b lat=%0d exp ok=1 lat=2", res_ok, res_lat); end
        checks++; if (res_err !== 1'b0 || res_to !== 1'b0 || res_rdata !== 32'h0) begin
            failures++; $display("FAIL wr_rsp got err=%b to=%b rdata=%h exp 0/0/0", res_err, res_to, res_rdata); end
        checks++; if (psel_cyc != 2 || pen_cyc != 1 || pen_bad || unstable) begin
            failures++; $display("FAIL wr_phases got psel=%0d pen=%0d penbad=%0b unstable=%0b exp 2/1/0/0", psel_cyc, pen_cyc, pen_bad, unstable); end
        checks++; if (res_rdy_in_resp !== 1'b0 || !res_hold || !res_drop) begin
            failures++; $display("FAIL wr_handshake got crdy=%b hold=%0b drop=%0b exp 0/1/1", res_rdy_in_resp, res_hold, res_drop); end
        do_cmd(1'b0, 32'h10, 32'h0, 4'hF);
        checks++; if (res_lat != 2 || res_rdata !== 32'hDEADBEEF || res_err !== 1'b0) begin
            failures++; $display("FAIL rd_data got lat=%0d rdata=%h err=%b exp 2/deadbeef/0", res_lat, res_rdata, res_err); end
        checks++; if (paddr !== 32'h10 || pprot !== 3'b010 || pwrite !== 1'b0) begin
            failures++; $display("FAIL rd_hold_bus got paddr=%h pprot=%b pwrite=%b exp 10/010/0", paddr, pprot, pwrite); end
    endtask

    task automatic test_strobes;
        do_cmd(1'b1, 32'h20, 32'h11223344, 4'hF);
        do_cmd(1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
        checks++; if (res_err !== 1'b0) begin
            failures++; $display("FAIL strb_wr_err got=%b exp=0", res_err); end
        do_cmd(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF);
        checks++; if (res_rdata !== 32'h11BB33DD) begin
            failures++; $display("FAIL strb_rdata got=%h exp=11bb33dd", res_rdata); end
        checks++; if (strb_bad || pwdata !== 32'h0) begin
            failures++; $display("FAIL strb_read_zero got strb_bad=%0b pwdata=%h exp 0/0", strb_bad, pwdata); end
    endtask

    task automatic test_misalign;
        do_cmd(1'b0, 32'h13, 32'h0, 4'hF);
        checks++; if (!res_ok || res_lat != 0 || psel_cyc != 0) begin
            failures++; $display("FAIL misalign_timing got ok=%0b lat=%0d psel=%0d exp 1/0/0", res_ok, res_lat, psel_cyc); end
        checks++; if (res_err !== 1'b1 || res_to !== 1'b0 || res_rdata !== 32'h0) begin
            failures++; $display("FAIL misalign_rsp got err=%b to=%b rdata=%h exp 1/0/0", res_err, res_to, res_rdata); end
    endtask

    task automatic test_timeout;
        mem[12] = 32'h0BAD_0BAD;
        cfg_stuck = 1;
        do_cmd(1'b0, 32'h30, 32'h0, 4'hF);
        cfg_stuck = 0;
        checks++; if (psel_cyc != 17 || pen_cyc != 16 || res_lat != 17) begin
            failures++; $display("FAIL timeout_len got psel=%0d pen=%0d lat=%0d exp 17/16/17", psel_cyc, pen_cyc, res_lat); end
        checks++; if (res_err !== 1'b1 || res_to !== 1'b1 || res_rdata !== 32'h0) begin
            failures++; $display("FAIL timeout_rsp got err=%b to=%b rdata=%h exp 1/1/0", res_err, res_to, res_rdata); end
        do_cmd(1'b0, 32'h30, 32'h0, 4'hF);
        checks++; if (res_lat != 2 || res_err !== 1'b0 || res_to !== 1'b0 || res_rdata !== 32'h0BAD0BAD) begin
            failures++; $display("FAIL after_timeout got lat=%0d err=%b to=%b rdata=%h exp 2/0/0/0bad0bad", res_lat, res_err, res_to, res_rdata); end
    endtask

    task automatic test_slverr;
        cfg_wait = 3; cfg_err = 1;
        do_cmd(1'b1, 32'h40, 32'h12345678, 4'hF);
        cfg_wait = 0; cfg_err = 0;
        checks++; if (pen_cyc != 4 || psel_cyc != 5 || res_lat != 5 || unstable) begin
            failures++; $display("FAIL slverr_len got pen=%0d psel=%0d lat=%0d unstable=%0b exp 4/5/5/0", pen_cyc, psel_cyc, res_lat, unstable); end
        checks++; if (res_err !== 1'b1 || res_to !== 1'b0 || res_rdata !== 32'h0) begin
            failures++; $display("FAIL slverr_rsp got err=%b to=%b rdata=%h exp 1/0/0", res_err, res_to, res_rdata); end
    endtask

    task automatic test_async_reset;
        cfg_wait = 5;
        issue(1'b1, 32'h10, 32'h0F0F0F0F, 4'hF);
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        checks++; if (penable !== 1'b1 || psel !== 1'b1) begin
            failures++; $display("FAIL arst_pre got psel=%b pen=%b exp 1/1", psel, penable); end
        #3; preset = 1'b1; #1;
        checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || pwdata !== 32'h0) begin
            failures++; $display("FAIL arst_immediate got psel=%b pen=%b rv=%b crdy=%b pwdata=%h exp all 0", psel, penable, rsp_valid, cmd_ready, pwdata); end
        @(posedge pclk); #1;
        preset = 1'b0; cfg_wait = 0;
        @(posedge pclk); #1;
        checks++; if (cmd_ready !== 1'b1 || psel !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL arst_release got crdy=%b psel=%b rv=%b exp 1/0/0", cmd_ready, psel, rsp_valid); end
        do_cmd(1'b0, 32'h10, 32'h0, 4'hF);
        checks++; if (res_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL arst_no_write got=%h exp=deadbeef", res_rdata); end
        do_cmd(1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
        do_cmd(1'b0, 32'h10, 32'h0, 4'hF);
        checks++; if (res_lat != 2 || res_err !== 1'b0 || res_rdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL arst_after got lat=%0d err=%b rdata=%h exp 2/0/cafef00d", res_lat, res_err, res_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_strobes();
        test_misalign();
        test_timeout();
        test_slverr();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
